pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage MIPS pipeline. It generates the per-stage enable and flush strobes that drive the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline register banks and the PC register. It detects three hazard classes:
- load-use hazards in ID/EX;
- control redirects (taken branch, jump, jr) resolved in the MEM stage;
- data-memory wait states.

It also keeps saturating performance counters and a memory-timeout watchdog.

## Interface
- `MEM_TIMEOUT`, default 64: maximum number of consecutive wait cycles before a fatal timeout.
- `CNT_W`, default 16: width of each performance counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `id_rs`, `id_rt`  in  5 each  source registers of the instruction in ID.
- `id_uses_rt`  in  1  the ID instruction reads `rt` (R-type, beq, bne, sw).
- `ex_mem_read`  in  1  the instruction in EX is a load.
- `ex_rt`  in  5  destination register of the load in EX.
- `mem_branch_taken`  in  1  `(BranchEQ & zero) | (BranchNE & ~zero)` in MEM.
- `mem_jump`, `mem_jr`  in  1 each  Jump/Jr control bits in MEM.
- `mem_access`  in  1  `MemRead | MemWrite` in MEM.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `pc_enable`, `if_id_enable`, `id_ex_enable`, `ex_mem_enable`, `mem_wb_enable`  out  1 each  register-bank enables.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`, `mem_wb_flush`  out  1 each  load a bubble (all control bits 0) on the next edge.
- `redirect`  out  1  PC mux selects the branch/jump target.
- `halted`  out  1  sticky memory-timeout error.
- `stall_cycles`, `flush_events`  out  `CNT_W` each  saturating counters.

## Operation
- FSM states:
  - `RUN`: normal operation.
  - `WAIT`: a data-memory access is outstanding.
  - `HALT`: terminal; left only by reset.
- Hazard terms, evaluated combinationally each cycle:
  - `redir = mem_branch_taken | mem_jump | mem_jr`.
  - `mwait = mem_access & ~mem_ready`.
  - `lu = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)))`.
- Priority is `HALT` > `redir` > `mwait` > `lu` > none. Branch/jump instructions never access memory, so if `redir` and `mwait` are both asserted, `redir` wins and the memory access is ignored.
- **`redir`:**
  - `redirect = 1`.
  - `if_id_flush`, `id_ex_flush` and `ex_mem_flush` are 1; all enables are 1.
  - `flush_events` increments.
  - The FSM stays in `RUN`.
- **`mwait`:**
  - PC, IF/ID, ID/EX and EX/MEM enables are 0; `mem_wb_flush = 1`; `mem_wb_enable = 1`.
  - FSM goes `RUN` → `WAIT`; the wait counter is loaded with 1.
  - `stall_cycles` increments.
- **`WAIT`:**
  - The same freeze pattern is held while `mem_ready = 0`; the wait counter increments.
  - On `mem_ready = 1`, all enables are 1 and the FSM goes to `RUN` in the same cycle.
  - If the wait counter reaches `MEM_TIMEOUT` with `mem_ready` still 0, the FSM goes to `HALT`.
- **`lu`:**
  - PC and IF/ID enables are 0; `id_ex_flush = 1`; all other enables are 1.
  - Exactly one bubble is inserted; `stall_cycles` increments.
  - A repeat of `lu` on the next cycle is impossible, because EX then holds a bubble.
- **`HALT`:** all enables 0, all flushes 0, `halted = 1`.
- **Counters:** saturate at all-ones and never wrap.
- **Reset values:** FSM `RUN`, both counters 0, wait counter 0, `halted = 0`. Enables and flushes are combinational; with idle inputs they settle to all enables 1, all flushes 0, `redirect = 0`.

## Timing
- All enable, flush and `redirect` outputs are combinational from the current state and the inputs, and take effect on the same rising edge.
- Redirect latency: target fetched 1 cycle after resolution; 3 instructions squashed.
- Load-use costs exactly 1 stall cycle.
- A memory wait of N cycles costs N stall cycles. `mem_ready` in the first access cycle costs 0.
- `HALT` is entered on the edge after the `MEM_TIMEOUT`-th consecutive not-ready cycle.
- Asserting reset mid-`WAIT` or mid-`HALT` returns the block to `RUN` immediately (asynchronously) and clears the counters.

## Structure
- Shared package `pipeline_pkg` holds:
  - the FSM state encoding (`RUN`/`WAIT`/`HALT`);
  - the register-number constant `REG_ZERO = 5'd0`;
  - the default `MEM_TIMEOUT`.
- One natural sub-module, `sat_counter` (parameterized width, increment input, saturating), instantiated twice.
- The hazard comparators and the FSM stay in the top level.

## Test plan
- **Load-use:** `ex_mem_read=1`, `ex_rt=8`, `id_rs=8` → for one cycle `pc_enable=0`, `if_id_enable=0`, `id_ex_flush=1`; `stall_cycles` 0→1. With `ex_rt=0` → no stall.
- **Taken branch:** `mem_branch_taken=1` for one cycle → `redirect=1`, three flushes=1, all enables=1; `flush_events=1`. Same result for `mem_jr=1`.
- **Memory wait:** `mem_access=1` with `mem_ready` low for 3 cycles, then high → front enables 0 for 3 cycles, `mem_wb_flush=1`, `stall_cycles=3`, FSM back in `RUN`.
- **Simultaneous `redir` + `mwait` + `lu`:** redirect pattern only; FSM stays `RUN`; `stall_cycles` unchanged.
- **Timeout:** `MEM_TIMEOUT=4`, `mem_ready` held 0 → `halted=1` after 4 cycles and all enables 0. Asserting reset → `halted=0`, counters 0.
- **Saturation:** `CNT_W=3`, 10 load-use events → `stall_cycles=7`.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard controller.
// FSM encoding, register constants and default timeout.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int DEF_MEM_TIMEOUT = 64;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // count up on inc, stick at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline.
// Handles load-use, redirects, memory waits and a timeout watchdog.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch_taken,
  input  logic             mem_jump,
  input  logic             mem_jr,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             id_ex_enable,
  output logic             ex_mem_enable,
  output logic             mem_wb_enable,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             redirect,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WCW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WLAST = WCW'(MEM_TIMEOUT - 1);

  hz_state_t      state;
  logic [WCW-1:0] wcnt;

  logic redir;
  logic mwait;
  logic lu;
  logic stall_inc;
  logic flush_inc;

  // hazard terms
  always_comb begin
    redir = mem_branch_taken | mem_jump | mem_jr;
    mwait = mem_access & ~mem_ready;
    lu    = ex_mem_read & (ex_rt != REG_ZERO)
          & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  end

  // per-stage enables/flushes from state and current hazards
  always_comb begin
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    id_ex_enable  = 1'b1;
    ex_mem_enable = 1'b1;
    mem_wb_enable = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_flush  = 1'b0;
    redirect      = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    unique case (state)
      RUN: begin
        if (redir) begin
          redirect     = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          flush_inc    = 1'b1;
        end else if (mwait) begin
          pc_enable     = 1'b0;
          if_id_enable  = 1'b0;
          id_ex_enable  = 1'b0;
          ex_mem_enable = 1'b0;
          mem_wb_flush  = 1'b1;
          stall_inc     = 1'b1;
        end else if (lu) begin
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          id_ex_flush  = 1'b1;
          stall_inc    = 1'b1;
        end
      end
      WAIT: begin
        if (!mem_ready) begin
          pc_enable     = 1'b0;
          if_id_enable  = 1'b0;
          id_ex_enable  = 1'b0;
          ex_mem_enable = 1'b0;
          mem_wb_flush  = 1'b1;
          stall_inc     = 1'b1;
        end
      end
      default: begin
        pc_enable     = 1'b0;
        if_id_enable  = 1'b0;
        id_ex_enable  = 1'b0;
        ex_mem_enable = 1'b0;
        mem_wb_enable = 1'b0;
      end
    endcase
  end

  // memory-wait FSM with timeout watchdog; halted is sticky
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= RUN;
      wcnt   <= '0;
      halted <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (!redir && mwait) begin
            wcnt <= WCW'(1);
            if (MEM_TIMEOUT <= 1) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_ready) begin
            state <= RUN;
            wcnt  <= '0;
          end else begin
            wcnt <= wcnt + 1'b1;
            if (wcnt == WLAST) begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end
        end
        default: begin
          state  <= HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_events)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// Small timeout and counter width exercise the boundaries.
module tb_pipeline_hazard_ctrl;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_uses_rt, ex_mem_read;
  logic          mem_branch_taken, mem_jump, mem_jr;
  logic          mem_access, mem_ready;
  logic          pc_enable, if_id_enable, id_ex_enable;
  logic          ex_mem_enable, mem_wb_enable;
  logic          if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic          redirect, halted;
  logic [CW-1:0] stall_cycles, flush_events;

  int n_chk  = 0;
  int n_fail = 0;

  logic [4:0] en;
  logic [3:0] fl;

  always #5 clk = ~clk;

  assign en = {pc_enable, if_id_enable, id_ex_enable,
               ex_mem_enable, mem_wb_enable};
  assign fl = {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (4),
    .CNT_W       (CW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_uses_rt       (id_uses_rt),
    .ex_mem_read      (ex_mem_read),
    .ex_rt            (ex_rt),
    .mem_branch_taken (mem_branch_taken),
    .mem_jump         (mem_jump),
    .mem_jr           (mem_jr),
    .mem_access       (mem_access),
    .mem_ready        (mem_ready),
    .pc_enable        (pc_enable),
    .if_id_enable     (if_id_enable),
    .id_ex_enable     (id_ex_enable),
    .ex_mem_enable    (ex_mem_enable),
    .mem_wb_enable    (mem_wb_enable),
    .if_id_flush      (if_id_flush),
    .id_ex_flush      (id_ex_flush),
    .ex_mem_flush     (ex_mem_flush),
    .mem_wb_flush     (mem_wb_flush),
    .redirect         (redirect),
    .halted           (halted),
    .stall_cycles     (stall_cycles),
    .flush_events     (flush_events)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [4:0] e,
                         input logic [3:0] f, input logic r);
    chk({tag, ".en"}, 32'(en), 32'(e));
    chk({tag, ".fl"}, 32'(fl), 32'(f));
    chk({tag, ".redir"}, 32'(redirect), 32'(r));
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rt = 0;
    id_uses_rt = 0; ex_mem_read = 0;
    mem_branch_taken = 0; mem_jump = 0; mem_jr = 0;
    mem_access = 0; mem_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
  endtask

  task automatic load_use();
    ex_mem_read = 1; ex_rt = 5'd8; id_rs = 5'd8;
    tick();
    idle();
    tick();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #12;
    reset = 1'b0;
    tick();

    chk_out("rst", 5'b11111, 4'b0000, 1'b0);
    chk("rst.halted", 32'(halted), 0);
    chk("rst.stall", 32'(stall_cycles), 0);
    chk("rst.flush", 32'(flush_events), 0);

    // load-use on rs
    ex_mem_read = 1; ex_rt = 5'd8; id_rs = 5'd8;
    #2 chk_out("lu", 5'b00111, 4'b0100, 1'b0);
    tick();
    chk("lu.stall", 32'(stall_cycles), 1);
    idle();
    #2 chk_out("lu.after", 5'b11111, 4'b0000, 1'b0);

    // ex_rt = 0 never stalls
    ex_mem_read = 1; ex_rt = 5'd0; id_rs = 5'd0;
    #2 chk_out("lu.r0", 5'b11111, 4'b0000, 1'b0);
    tick();
    chk("lu.r0.stall", 32'(stall_cycles), 1);

    // rt match only counts when the instruction reads rt
    idle();
    ex_mem_read = 1; ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3;
    #2 chk_out("lu.rt_unused", 5'b11111, 4'b0000, 1'b0);
    id_uses_rt = 1;
    #1 chk_out("lu.rt_used", 5'b00111, 4'b0100, 1'b0);
    tick();
    chk("lu.rt.stall", 32'(stall_cycles), 2);
    idle();

    // taken branch, then jr
    mem_branch_taken = 1;
    #2 chk_out("br", 5'b11111, 4'b1110, 1'b1);
    tick();
    chk("br.cnt", 32'(flush_events), 1);
    idle();
    mem_jr = 1;
    #2 chk_out("jr", 5'b11111, 4'b1110, 1'b1);
    tick();
    chk("jr.cnt", 32'(flush_events), 2);
    idle();

    // ready in first access cycle costs nothing
    do_reset();
    mem_access = 1; mem_ready = 1;
    #2 chk_out("mem.fast", 5'b11111, 4'b0000, 1'b0);
    tick();
    chk("mem.fast.stall", 32'(stall_cycles), 0);

    // three wait cycles (one below timeout), then ready
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #2 chk_out($sformatf("mem.w%0d", i), 5'b00001, 4'b0001, 1'b0);
      tick();
    end
    mem_ready = 1;
    #2 chk_out("mem.done", 5'b11111, 4'b0000, 1'b0);
    tick();
    chk("mem.stall", 32'(stall_cycles), 3);
    chk("mem.halted", 32'(halted), 0);
    idle();
    #2 chk_out("mem.run", 5'b11111, 4'b0000, 1'b0);

    // redirect + memory wait + load-use together
    do_reset();
    mem_branch_taken = 1; mem_access = 1; mem_ready = 0;
    ex_mem_read = 1; ex_rt = 5'd4; id_rs = 5'd4;
    #2 chk_out("all3", 5'b11111, 4'b1110, 1'b1);
    tick();
    chk("all3.stall", 32'(stall_cycles), 0);
    chk("all3.flush", 32'(flush_events), 1);
    idle();
    #2 chk_out("all3.run", 5'b11111, 4'b0000, 1'b0);

    // timeout after four not-ready cycles
    do_reset();
    mem_access = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to.nohalt%0d", i), 32'(halted), 0);
      #2 chk_out($sformatf("to.w%0d", i), 5'b00001, 4'b0001, 1'b0);
      tick();
    end
    chk("to.halted", 32'(halted), 1);
    chk_out("to.frozen", 5'b00000, 4'b0000, 1'b0);
    chk("to.stall", 32'(stall_cycles), 4);
    mem_ready = 1; mem_branch_taken = 1;
    tick();
    chk_out("to.sticky", 5'b00000, 4'b0000, 1'b0);
    idle();

    // asynchronous reset out of HALT
    #2 reset = 1'b1;
    #1 chk("to.rst.halted", 32'(halted), 0);
    chk("to.rst.stall", 32'(stall_cycles), 0);
    chk_out("to.rst", 5'b11111, 4'b0000, 1'b0);
    reset = 1'b0;
    tick();

    // saturation: ten load-use events on a 3-bit counter
    for (int i = 0; i < 10; i++) load_use();
    chk("sat.stall", 32'(stall_cycles), 7);
    chk("sat.flush", 32'(flush_events), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
